pipe_stage_reg: RTL and testbench

//   Parametrised inter-stage pipeline register for the MIPS core, replacing the free-running stage latches.

---
 rtl/pipe_stage_reg.sv | 127 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with a valid/ready handshake,
// a one-deep skid entry that absorbs a single stall, and flush with bubble insertion.
// Optional build macro: PIPE_REG_PERF_EN adds saturating stall/flush counters.
module pipe_stage_reg #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_REG_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    // A zero-width bundle or counter has no meaning here; refuse to elaborate.
    if (DATA_W < 1 || CTRL_W < 1 || CNT_W < 1) begin : g_param_check
        $error("pipe_stage_reg: DATA_W, CTRL_W and CNT_W must all be >= 1");
    end

    // SKID means both the output register and the overflow entry hold bundles.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic              in_fire;

    // Ready depends only on registered state and rst, never on in_valid.
    assign in_ready  = rst & (state_q != ST_EMPTY ? state_q != ST_SKID : 1'b1);
    assign in_fire   = in_valid & in_ready;
    // Gating with rst keeps a reset cycle from ever showing a completed transfer.
    assign out_valid = rst & (state_q != ST_EMPTY);
    assign out_data  = main_data_q;
    // Bubbles must never leak control bits such as RegWrite downstream.
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;

    // Handshake FSM: reset beats flush, flush beats the normal transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else if (flush) begin
            // Held entries and this cycle's input are dropped; out_data keeps its last value.
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_q     <= ST_FULL;
                        main_data_q <= in_data;
                        main_ctrl_q <= in_ctrl;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (in_fire) begin
                            main_data_q <= in_data;
                            main_ctrl_q <= in_ctrl;
                        end else begin
                            state_q <= ST_EMPTY;
                        end
                    end else if (in_fire) begin
                        // Output is stalled: park the newer bundle behind the held one.
                        state_q     <= ST_SKID;
                        skid_data_q <= in_data;
                        skid_ctrl_q <= in_ctrl;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        state_q     <= ST_FULL;
                        main_data_q <= skid_data_q;
                        main_ctrl_q <= skid_ctrl_q;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_REG_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Saturating perf counters; only reset clears them, flush leaves them alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush && state_q != ST_EMPTY && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scenarios followed by a randomized run, every cycle
// compared against a two-deep FIFO reference model of the pipeline register.
module tb_pipe_stage_reg;

    localparam int DATA_W = 69;
    localparam int CTRL_W = 2;
`ifdef PIPE_REG_PERF_EN
    localparam int CNT_W  = 4;
`else
    localparam int CNT_W  = 16;
`endif
    localparam int BW     = DATA_W + CTRL_W;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_REG_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl)
`ifdef PIPE_REG_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a FIFO of capacity two plus the last value shown on out_data.
    logic [BW-1:0]     q[$];
    logic [DATA_W-1:0] last_out = '0;
    int                m_stall = 0;
    int                m_flush = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DATA_W-1:0];
    endfunction

    // Apply the inputs sampled at the edge that just happened to the model.
    task automatic model_step();
        int n;
        bit fi;
        bit fo;
        n = q.size();
        if (!rst) begin
            q.delete();
            last_out = '0;
            m_stall  = 0;
            m_flush  = 0;
        end else begin
            if (n > 0 && !out_ready && m_stall < MAXC) m_stall++;
            if (flush && n > 0 && m_flush < MAXC) m_flush++;
            if (flush) begin
                q.delete();
            end else begin
                fi = in_valid && (n < 2);
                fo = (n > 0) && out_ready;
                if (fo) void'(q.pop_front());
                if (fi) q.push_back({in_ctrl, in_data});
            end
            if (q.size() > 0) last_out = q[0][DATA_W-1:0];
        end
    endtask

    task automatic check_all();
        logic             ev;
        logic             er;
        logic [BW-1:0]    head;
        logic [CTRL_W-1:0] ec;
        ev   = rst && (q.size() > 0);
        er   = rst && (q.size() < 2);
        head = (q.size() > 0) ? q[0] : '0;
        ec   = ev ? head[BW-1:DATA_W] : '0;
        chk("out_valid", out_valid, ev);
        chk("in_ready", in_ready, er);
        chk("out_ctrl", out_ctrl, ec);
        chk("out_data", out_data, last_out);
`ifdef PIPE_REG_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c, input logic ordy);
        in_valid  = 1'b1;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        cycle();
    endtask

    logic [DATA_W-1:0] sent[8];
    logic [DATA_W-1:0] a_d;
    logic [DATA_W-1:0] b_d;
    logic [DATA_W-1:0] c_d;

    initial begin
        // Reset state, including in_ready held low while rst=0.
        rst = 1'b0;
        cycle();
        cycle();
        chk("rst_out_data", out_data, '0);
        chk("rst_in_ready", in_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1'b1);

        // Scenario 1: one-cycle latency then eight bundles streamed back to back.
        for (int i = 0; i < 8; i++) begin
            sent[i] = rand_data();
            if (i == 0) sent[i][7:0] = 8'hA5;
            push(sent[i], (i == 0) ? 2'b11 : CTRL_W'($urandom), 1'b1);
            chk("s1_valid", out_valid, 1'b1);
            chk("s1_data", out_data, sent[i]);
            if (i == 0) chk("s1_ctrl", out_ctrl, 2'b11);
        end
        in_valid = 1'b0;
        cycle();
        chk("s1_drain", out_valid, 1'b0);

        // Scenario 2: stall fills the skid entry; release drains A then B.
        a_d = rand_data();
        b_d = rand_data();
        push(a_d, 2'b01, 1'b1);
        push(b_d, 2'b10, 1'b0);
        chk("s2_skid_ready", in_ready, 1'b0);
        chk("s2_hold_a", out_data, a_d);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        chk("s2_b_data", out_data, b_d);
        chk("s2_b_ctrl", out_ctrl, 2'b10);
        chk("s2_ready_back", in_ready, 1'b1);
        cycle();
        chk("s2_empty", out_valid, 1'b0);

        // Scenario 3: flush while in SKID with a new bundle offered.
        push(rand_data(), 2'b11, 1'b1);
        push(rand_data(), 2'b11, 1'b0);
        c_d   = rand_data();
        flush = 1'b1;
        push(c_d, 2'b11, 1'b0);
        chk("s3_valid", out_valid, 1'b0);
        chk("s3_ctrl", out_ctrl, 2'b00);
        chk("s3_ready", in_ready, 1'b1);
        flush    = 1'b0;
        in_valid = 1'b0;
        cycle();
        chk("s3_no_leak", out_valid, 1'b0);

        // Scenario 4: reset while in SKID.
        push(rand_data(), 2'b11, 1'b1);
        push(rand_data(), 2'b11, 1'b0);
        rst = 1'b0;
        cycle();
        chk("s4_valid", out_valid, 1'b0);
        chk("s4_data", out_data, '0);
        chk("s4_ctrl", out_ctrl, 2'b00);
        chk("s4_ready", in_ready, 1'b0);
        push(rand_data(), 2'b11, 1'b1);
        chk("s4_ready_in_rst", in_ready, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b0;
        cycle();
        chk("s4_ready_after", in_ready, 1'b1);

`ifdef PIPE_REG_PERF_EN
        // Scenario 6: counter saturation and flush counting.
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        push(rand_data(), 2'b01, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        chk("s6_stall_sat", stall_cnt, 4'd15);
        flush = 1'b1;
        cycle();
        chk("s6_flush_full", flush_cnt, 4'd1);
        cycle();
        chk("s6_flush_empty", flush_cnt, 4'd1);
        flush = 1'b0;
        cycle();
`endif

        // Scenario 5: random traffic against the FIFO model.
        for (int i = 0; i < 10000; i++) begin
            rst       = ($urandom_range(0, 499) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = rand_data();
            in_ctrl   = CTRL_W'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
